dff_stream_checker: RTL and testbench

- Receiving end of the D flip-flop stimulus stream.
- Observes the stimulus bit D and the DUT outputs Q/Qn on the shared CLK, and checks that the DUT captured each bit correctly.
- Checks that Qn is the complement of Q.
- Keeps error and bit counters and a history shift register of captured bits.
- Raises a sticky FAULT after a programmable number of errors.
- Sits beside the flip-flop DUT in the quiz test harness, on the same CLK/CLR nets.

---
 rtl/dff_stream_checker_if.sv | 36 +++
 rtl/dff_stream_checker.sv | 116 +++++++++++
 tb/tb_dff_stream_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dff_stream_checker_if.sv
// Stream-checker bundle: stimulus bit, DUT Q/Qn observation and checker results.
// TOGGLE_CNT exists only when DFF_CHK_TOGGLE_EN is defined.
interface dff_stream_checker_if #(
  parameter int CNT_W  = 8,
  parameter int HIST_W = 8
);
  logic              EN;
  logic              D;
  logic              Q;
  logic              Qn;
  logic [CNT_W-1:0]  BIT_CNT;
  logic [CNT_W-1:0]  ERR_CNT;
  logic [HIST_W-1:0] HIST;
  logic              MISMATCH;
  logic              FAULT;
  logic [1:0]        STATE;
`ifdef DFF_CHK_TOGGLE_EN
  logic [CNT_W-1:0]  TOGGLE_CNT;
`endif

  modport master (
    output EN, D, Q, Qn,
    input  BIT_CNT, ERR_CNT, HIST, MISMATCH, FAULT, STATE
`ifdef DFF_CHK_TOGGLE_EN
    , input TOGGLE_CNT
`endif
  );

  modport slave (
    input  EN, D, Q, Qn,
    output BIT_CNT, ERR_CNT, HIST, MISMATCH, FAULT, STATE
`ifdef DFF_CHK_TOGGLE_EN
    , output TOGGLE_CNT
`endif
  );
endinterface

// File: rtl/dff_stream_checker.sv
// Checks that a D flip-flop captured each stimulus bit and that Qn == ~Q.
// Optional DFF_CHK_TOGGLE_EN adds a Q-transition counter (TOGGLE_CNT).
module dff_stream_checker #(
  parameter int CNT_W   = 8,
  parameter int HIST_W  = 8,
  parameter int MAX_ERR = 3
) (
  input logic                 CLK,
  input logic                 CLR,
  dff_stream_checker_if.slave chk
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    CHECK = 2'b10,
    FLT   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MAX_ERR_V = CNT_W'(MAX_ERR);

  state_t            state, state_nxt;
  logic              d_prev, d_prev_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]  err_cnt, err_cnt_nxt;
  logic [HIST_W-1:0] hist, hist_nxt;
  logic              mismatch, mismatch_nxt;
  logic              fault, fault_nxt;
  logic              err;
`ifdef DFF_CHK_TOGGLE_EN
  logic [CNT_W-1:0]  toggle_cnt, toggle_cnt_nxt;
`endif

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= IDLE;
      d_prev   <= 1'b0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      hist     <= '0;
      mismatch <= 1'b0;
      fault    <= 1'b0;
`ifdef DFF_CHK_TOGGLE_EN
      toggle_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      d_prev   <= d_prev_nxt;
      bit_cnt  <= bit_cnt_nxt;
      err_cnt  <= err_cnt_nxt;
      hist     <= hist_nxt;
      mismatch <= mismatch_nxt;
      fault    <= fault_nxt;
`ifdef DFF_CHK_TOGGLE_EN
      toggle_cnt <= toggle_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    d_prev_nxt   = d_prev;
    bit_cnt_nxt  = bit_cnt;
    err_cnt_nxt  = err_cnt;
    hist_nxt     = hist;
    mismatch_nxt = 1'b0;
    fault_nxt    = fault;
    err          = 1'b0;
`ifdef DFF_CHK_TOGGLE_EN
    toggle_cnt_nxt = toggle_cnt;
`endif

    // EN low wins over every state, including a pending FLT entry.
    if (!chk.EN) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = PRIME;
        PRIME: begin
          d_prev_nxt = chk.D;
          state_nxt  = CHECK;
        end
        CHECK: begin
          d_prev_nxt  = chk.D;
          hist_nxt    = {hist[HIST_W-2:0], chk.Q};
          bit_cnt_nxt = bit_cnt + 1'b1;
          err         = (chk.Q != d_prev) || (chk.Qn != ~chk.Q);
`ifdef DFF_CHK_TOGGLE_EN
          if (chk.Q != hist[0]) toggle_cnt_nxt = toggle_cnt + 1'b1;
`endif
          if (err) begin
            mismatch_nxt = 1'b1;
            err_cnt_nxt  = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
            if (err_cnt_nxt == MAX_ERR_V) begin
              state_nxt = FLT;
              fault_nxt = 1'b1;
            end
          end
        end
        FLT: state_nxt = FLT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign chk.STATE    = state;
  assign chk.BIT_CNT  = bit_cnt;
  assign chk.ERR_CNT  = err_cnt;
  assign chk.HIST     = hist;
  assign chk.MISMATCH = mismatch;
  assign chk.FAULT    = fault;
`ifdef DFF_CHK_TOGGLE_EN
  assign chk.TOGGLE_CNT = toggle_cnt;
`endif

endmodule

// File: tb/tb_dff_stream_checker.sv
// Bench for dff_stream_checker: vector table on an 8-bit/MAX_ERR=3 instance,
// wrap/saturation sequence on a 4-bit/MAX_ERR=15 instance.
module tb_dff_stream_checker;

  logic clk = 1'b0;
  logic clr_a, clr_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dff_stream_checker_if #(.CNT_W(8), .HIST_W(8)) ifa ();
  dff_stream_checker_if #(.CNT_W(4), .HIST_W(8)) ifb ();

  dff_stream_checker #(.CNT_W(8), .HIST_W(8), .MAX_ERR(3)) dut_a (
    .CLK(clk), .CLR(clr_a), .chk(ifa)
  );
  dff_stream_checker #(.CNT_W(4), .HIST_W(8), .MAX_ERR(15)) dut_b (
    .CLK(clk), .CLR(clr_b), .chk(ifb)
  );

  typedef struct {
    logic       clr, en, d, q, qn;
    logic [1:0] st;
    logic [7:0] bc, ec, hist;
    logic       mis, mis_dc, flt;
  } vec_t;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] bc, ec;
    logic       flt;
  } exp_b_t;

  vec_t   vecs[27];
  vec_t   exp_q[$];
  exp_b_t exp_bq[$];

  function automatic vec_t v(input logic clr, en, d, q, qn,
                             input logic [1:0] st, input logic [7:0] bc, ec, hist,
                             input logic mis, mis_dc, flt);
    vec_t r;
    r.clr = clr; r.en = en; r.d = d; r.q = q; r.qn = qn;
    r.st = st; r.bc = bc; r.ec = ec; r.hist = hist;
    r.mis = mis; r.mis_dc = mis_dc; r.flt = flt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_a(input string tag, input vec_t vin);
    vec_t e;
    @(negedge clk);
    clr_a = vin.clr; ifa.EN = vin.en; ifa.D = vin.d; ifa.Q = vin.q; ifa.Qn = vin.qn;
    exp_q.push_back(vin);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " STATE"},   32'(ifa.STATE),   32'(e.st));
    chk({tag, " BIT_CNT"}, 32'(ifa.BIT_CNT), 32'(e.bc));
    chk({tag, " ERR_CNT"}, 32'(ifa.ERR_CNT), 32'(e.ec));
    chk({tag, " HIST"},    32'(ifa.HIST),    32'(e.hist));
    chk({tag, " FAULT"},   32'(ifa.FAULT),   32'(e.flt));
    if (!e.mis_dc) chk({tag, " MISMATCH"}, 32'(ifa.MISMATCH), 32'(e.mis));
  endtask

  task automatic apply_b(input logic clr, en, d, q, qn, input exp_b_t e_in);
    exp_b_t e;
    @(negedge clk);
    clr_b = clr; ifb.EN = en; ifb.D = d; ifb.Q = q; ifb.Qn = qn;
    exp_bq.push_back(e_in);
    @(posedge clk);
    #1;
    e = exp_bq.pop_front();
    chk({e.tag, " STATE"},   32'(ifb.STATE),   32'(e.st));
    chk({e.tag, " BIT_CNT"}, 32'(ifb.BIT_CNT), 32'(e.bc));
    chk({e.tag, " ERR_CNT"}, 32'(ifb.ERR_CNT), 32'(e.ec));
    chk({e.tag, " FAULT"},   32'(ifb.FAULT),   32'(e.flt));
  endtask

  function automatic exp_b_t eb(input string tag, input logic [1:0] st,
                                input int bc, input int ec, input logic flt);
    exp_b_t r;
    r.tag = tag; r.st = st; r.bc = 4'(bc); r.ec = 4'(ec); r.flt = flt;
    return r;
  endfunction

  initial begin
    clr_a = 1'b0; clr_b = 1'b0;
    ifa.EN = 1'b0; ifa.D = 1'b0; ifa.Q = 1'b0; ifa.Qn = 1'b1;
    ifb.EN = 1'b0; ifb.D = 1'b0; ifb.Q = 1'b0; ifb.Qn = 1'b1;

    //             clr en d q qn   st  bc  ec  hist  mis dc flt
    vecs[0]  = v(0, 1, 1, 0, 0, 2'd0, 0, 0, 8'h00, 0, 0, 0);
    vecs[1]  = v(0, 1, 0, 1, 1, 2'd0, 0, 0, 8'h00, 0, 0, 0);
    vecs[2]  = v(0, 1, 1, 1, 0, 2'd0, 0, 0, 8'h00, 0, 0, 0);
    vecs[3]  = v(1, 1, 0, 0, 1, 2'd1, 0, 0, 8'h00, 0, 0, 0);
    vecs[4]  = v(1, 1, 1, 0, 1, 2'd2, 0, 0, 8'h00, 0, 0, 0);
    vecs[5]  = v(1, 1, 0, 1, 0, 2'd2, 1, 0, 8'h01, 0, 0, 0);
    vecs[6]  = v(1, 1, 1, 0, 1, 2'd2, 2, 0, 8'h02, 0, 0, 0);
    vecs[7]  = v(1, 1, 1, 1, 0, 2'd2, 3, 0, 8'h05, 0, 0, 0);
    vecs[8]  = v(1, 1, 0, 1, 0, 2'd2, 4, 0, 8'h0B, 0, 0, 0);
    vecs[9]  = v(1, 1, 1, 0, 1, 2'd2, 5, 0, 8'h16, 0, 0, 0);
    vecs[10] = v(1, 1, 0, 1, 0, 2'd2, 6, 0, 8'h2D, 0, 0, 0);
    vecs[11] = v(1, 1, 1, 0, 1, 2'd2, 7, 0, 8'h5A, 0, 0, 0);
    vecs[12] = v(1, 1, 0, 0, 1, 2'd2, 8, 1, 8'hB4, 1, 0, 0);
    vecs[13] = v(1, 1, 0, 0, 1, 2'd2, 9, 1, 8'h68, 0, 0, 0);
    vecs[14] = v(0, 1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 0, 0);
    vecs[15] = v(1, 1, 1, 0, 1, 2'd1, 0, 0, 8'h00, 0, 0, 0);
    vecs[16] = v(1, 1, 1, 0, 1, 2'd2, 0, 0, 8'h00, 0, 0, 0);
    vecs[17] = v(1, 1, 1, 1, 1, 2'd2, 1, 1, 8'h01, 1, 0, 0);
    vecs[18] = v(1, 1, 1, 1, 1, 2'd2, 2, 2, 8'h03, 1, 0, 0);
    vecs[19] = v(1, 1, 1, 1, 1, 2'd3, 3, 3, 8'h07, 0, 1, 1);
    vecs[20] = v(1, 1, 0, 0, 0, 2'd3, 3, 3, 8'h07, 0, 0, 1);
    vecs[21] = v(1, 1, 1, 1, 1, 2'd3, 3, 3, 8'h07, 0, 0, 1);
    vecs[22] = v(1, 0, 0, 0, 1, 2'd0, 3, 3, 8'h07, 0, 0, 1);
    vecs[23] = v(0, 0, 0, 0, 1, 2'd0, 0, 0, 8'h00, 0, 0, 0);
    vecs[24] = v(1, 1, 0, 0, 1, 2'd1, 0, 0, 8'h00, 0, 0, 0);
    vecs[25] = v(1, 1, 1, 0, 1, 2'd2, 0, 0, 8'h00, 0, 0, 0);
    vecs[26] = v(1, 1, 0, 1, 0, 2'd2, 1, 0, 8'h01, 0, 0, 0);

    for (int i = 0; i < 27; i++) begin
      apply_a($sformatf("v%0d", i), vecs[i]);
`ifdef DFF_CHK_TOGGLE_EN
      if (i == 11) chk("clean TOGGLE_CNT", 32'(ifa.TOGGLE_CNT), 32'd6);
`endif
    end

    // Asynchronous clear mid-cycle, observed before the next edge.
    @(negedge clk);
    clr_a = 1'b0;
    #1;
    chk("async STATE",   32'(ifa.STATE),   32'd0);
    chk("async BIT_CNT", 32'(ifa.BIT_CNT), 32'd0);
    chk("async HIST",    32'(ifa.HIST),    32'd0);

    // EN=0 on what would be the MAX_ERR-th error: no check, no fault.
    apply_a("en_dom0", v(0, 0, 0, 0, 1, 2'd0, 0, 0, 8'h00, 0, 0, 0));
    apply_a("en_dom1", v(1, 1, 1, 0, 1, 2'd1, 0, 0, 8'h00, 0, 0, 0));
    apply_a("en_dom2", v(1, 1, 1, 0, 1, 2'd2, 0, 0, 8'h00, 0, 0, 0));
    apply_a("en_dom3", v(1, 1, 1, 1, 1, 2'd2, 1, 1, 8'h01, 1, 0, 0));
    apply_a("en_dom4", v(1, 1, 1, 1, 1, 2'd2, 2, 2, 8'h03, 1, 0, 0));
    apply_a("en_dom5", v(1, 0, 1, 1, 1, 2'd0, 2, 2, 8'h03, 0, 0, 0));

    // Narrow counters: BIT_CNT wrap, ERR_CNT reaching MAX_ERR=15 then freezing.
    apply_b(0, 0, 0, 0, 1, eb("b_rst", 2'd0, 0, 0, 0));
    apply_b(1, 1, 0, 0, 1, eb("b_prime", 2'd1, 0, 0, 0));
    apply_b(1, 1, 0, 0, 1, eb("b_check", 2'd2, 0, 0, 0));
    for (int i = 1; i <= 17; i++)
      apply_b(1, 1, 0, 0, 1, eb($sformatf("b_clean%0d", i), 2'd2, i % 16, 0, 0));
    for (int i = 1; i <= 20; i++) begin
      if (i < 15)
        apply_b(1, 1, 0, 1, 0, eb($sformatf("b_err%0d", i), 2'd2, (17 + i) % 16, i, 0));
      else
        apply_b(1, 1, 0, 1, 0, eb($sformatf("b_err%0d", i), 2'd3, 0, 15, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
